// File: rtl/mips_pkg.sv
// Shared P5 MIPS core definitions.
// Reset values, next-PC select encoding and redirect opcodes.
package mips_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    NPC_PC4 = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] FN_JR      = 6'h08;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory fetch bus.
// Address out from fetch, combinational read data back.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  modport master (
    output imem_addr,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    output imem_rdata
  );
endinterface

// File: rtl/npc_calc.sv
// Next-PC datapath for the fetch stage.
// Redirect targets are derived from the D-stage instruction.
module npc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] pc_d,
  input  logic [31:0] instr_d,
  input  logic [31:0] rs_val_d,
  input  npc_sel_e    sel,
  output logic [31:0] npc
);

  logic [31:0] br_off;
  logic        unused_opcode;

  assign br_off = {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
  assign unused_opcode = ^instr_d[31:26];

  // Select the next fetch address; all sums wrap mod 2^32.
  always_comb begin
    npc = pc + 32'd4;
    unique case (sel)
      NPC_PC4: npc = pc + 32'd4;
      NPC_BR:  npc = pc_d + 32'd4 + br_off;
      NPC_J:   npc = {pc_d[31:28], instr_d[25:0], 2'b00};
      NPC_JR:  npc = rs_val_d;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID register of the P5 MIPS core.
// The delay-slot word is always latched; there is no flush.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
  parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall,
  input  logic               take_branch_D,
  input  logic               jump_D,
  input  logic               jr_D,
  input  logic [31:0]        rs_val_D,
  fetch_stage_if.master      imem,
  output logic [31:0]        instr_D,
  output logic [31:0]        pc_D,
  output logic [31:0]        pc8_D,
  output logic               valid_D
);

  import mips_pkg::*;

  logic [31:0] pc;
  logic [31:0] npc;
  npc_sel_e    sel;
  if_id_t      id_q;

  assign imem.imem_addr = pc;
  assign instr_D = id_q.instr;
  assign pc_D    = id_q.pc;
  assign pc8_D   = id_q.pc8;
  assign valid_D = id_q.valid;

  // Fixed-priority redirect select: jr, jump, branch, sequential.
  always_comb begin
    sel = NPC_PC4;
    priority case (1'b1)
      jr_D:          sel = NPC_JR;
      jump_D:        sel = NPC_J;
      take_branch_D: sel = NPC_BR;
      default:       sel = NPC_PC4;
    endcase
  end

  npc_calc u_npc (
    .pc       (pc),
    .pc_d     (id_q.pc),
    .instr_d  (id_q.instr),
    .rs_val_d (rs_val_D),
    .sel      (sel),
    .npc      (npc)
  );

  // PC and IF/ID register; stall freezes both.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc         <= RESET_PC;
      id_q.instr <= NOP_WORD;
      id_q.pc    <= 32'd0;
      id_q.pc8   <= 32'd8;
      id_q.valid <= 1'b0;
    end else if (!stall) begin
      pc         <= npc;
      id_q.instr <= imem.imem_rdata;
      id_q.pc    <= pc;
      id_q.pc8   <= pc + 32'd8;
      id_q.valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage.
// Memory returns address-tagged words except for a beq and a jal.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        take_branch_D;
  logic        jump_D;
  logic        jr_D;
  logic [31:0] rs_val_D;
  logic [31:0] instr_D;
  logic [31:0] pc_D;
  logic [31:0] pc8_D;
  logic        valid_D;

  int checks = 0;
  int errors = 0;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall         (stall),
    .take_branch_D (take_branch_D),
    .jump_D        (jump_D),
    .jr_D          (jr_D),
    .rs_val_D      (rs_val_D),
    .imem          (bus.master),
    .instr_D       (instr_D),
    .pc_D          (pc_D),
    .pc8_D         (pc8_D),
    .valid_D       (valid_D)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_3004: mem_word = 32'h1000_FFFF;
      32'h0000_3010: mem_word = 32'h0C00_0C10;
      default:       mem_word = a;
    endcase
  endfunction

  always_comb bus.imem_rdata = mem_word(bus.imem_addr);

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    stall = 1'b0;
    take_branch_D = 1'b0;
    jump_D = 1'b0;
    jr_D = 1'b0;
    rs_val_D = 32'd0;
    step();
    step();
    check("rst_addr", bus.imem_addr, 32'h0000_3000);
    check("rst_instr", instr_D, 32'h0000_0000);
    check("rst_pcd", pc_D, 32'h0);
    check("rst_pc8", pc8_D, 32'h8);
    check("rst_valid", {31'd0, valid_D}, 32'd0);

    reset_n = 1'b1;
    step();
    check("e1_addr", bus.imem_addr, 32'h0000_3004);
    check("e1_instr", instr_D, 32'h0000_3000);
    check("e1_pcd", pc_D, 32'h0000_3000);
    check("e1_pc8", pc8_D, 32'h0000_3008);
    check("e1_valid", {31'd0, valid_D}, 32'd1);

    step();
    check("e2_addr", bus.imem_addr, 32'h0000_3008);
    check("e2_instr", instr_D, 32'h1000_FFFF);
    take_branch_D = 1'b1;
    step();
    take_branch_D = 1'b0;
    check("beq_addr", bus.imem_addr, 32'h0000_3004);
    check("beq_slot", instr_D, 32'h0000_3008);
    check("beq_pcd", pc_D, 32'h0000_3008);

    step();
    step();
    step();
    step();
    check("jal_instr", instr_D, 32'h0C00_0C10);
    check("jal_pcd", pc_D, 32'h0000_3010);
    check("jal_pc8", pc8_D, 32'h0000_3018);
    check("jal_fetch", bus.imem_addr, 32'h0000_3014);
    jump_D = 1'b1;
    step();
    jump_D = 1'b0;
    check("jal_addr", bus.imem_addr, 32'h0000_3040);
    check("jal_slot", instr_D, 32'h0000_3014);

    step();
    check("jr_pre_pcd", pc_D, 32'h0000_3040);
    jr_D = 1'b1;
    rs_val_D = 32'h0000_3100;
    stall = 1'b1;
    step();
    check("stl1_addr", bus.imem_addr, 32'h0000_3044);
    check("stl1_instr", instr_D, 32'h0000_3040);
    check("stl1_pcd", pc_D, 32'h0000_3040);
    step();
    check("stl2_addr", bus.imem_addr, 32'h0000_3044);
    check("stl2_instr", instr_D, 32'h0000_3040);
    stall = 1'b0;
    step();
    jr_D = 1'b0;
    check("jr_addr", bus.imem_addr, 32'h0000_3100);
    check("jr_slot", instr_D, 32'h0000_3044);

    stall = 1'b1;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_addr", bus.imem_addr, 32'h0000_3000);
    check("arst_instr", instr_D, 32'h0000_0000);
    check("arst_pcd", pc_D, 32'h0);
    check("arst_pc8", pc8_D, 32'h8);
    check("arst_valid", {31'd0, valid_D}, 32'd0);
    reset_n = 1'b1;
    stall = 1'b0;
    step();
    check("rel_addr", bus.imem_addr, 32'h0000_3004);
    check("rel_valid", {31'd0, valid_D}, 32'd1);

    jr_D = 1'b1;
    rs_val_D = 32'h0000_3102;
    step();
    check("mis_addr", bus.imem_addr, 32'h0000_3102);
    rs_val_D = 32'hFFFF_FFFC;
    step();
    jr_D = 1'b0;
    check("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_addr", bus.imem_addr, 32'h0000_0000);
    check("wrap_pcd", pc_D, 32'hFFFF_FFFC);
    check("wrap_pc8", pc8_D, 32'h0000_0004);
    take_branch_D = 1'b1;
    step();
    take_branch_D = 1'b0;
    check("nbr_addr", bus.imem_addr, 32'hFFFF_FFF0);
    check("nbr_slot", instr_D, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
